// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory bus bundle for the load/store unit
interface load_store_unit_if #(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_half;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_w;
  logic              mem_r;
  logic [31:0]       mem_rdata;

  // slave: the load/store unit itself
  modport slave (
    input  req_valid, req_write, req_half, req_signed, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_wdata, mem_w, mem_r,
    input  mem_rdata
  );

  // master: execute stage plus data memory facing the unit
  modport master (
    output req_valid, req_write, req_half, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_wdata, mem_w, mem_r,
    output mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - word/half load-store initiator for a 16-bit data memory; optional LSU_ALIGN_CHECK_EN
module load_store_unit #(
  parameter int ADDR_W    = 16,
  parameter int MEM_BYTES = 512
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t            state, state_nx;
  logic              write_q, half_q, signed_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [15:0]       lo_q, hi_q;

  logic              accept;
  logic [ADDR_W-1:0] addr_eff;
  logic [ADDR_W:0]   last_byte;
  logic              align_err, range_err;

  assign accept = bus.req_valid && (state == IDLE);

  always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
    addr_eff  = bus.req_addr;
    align_err = bus.req_half ? bus.req_addr[0] : (bus.req_addr[1:0] != 2'b00);
`else
    addr_eff  = bus.req_addr & ~ADDR_W'(bus.req_half ? 1 : 3);
    align_err = 1'b0;
`endif
    // one extra bit so the last-byte check cannot wrap at the top of the address space
    last_byte = {1'b0, addr_eff} + (ADDR_W+1)'(bus.req_half ? 1 : 3);
    range_err = last_byte >= (ADDR_W+1)'(MEM_BYTES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      write_q  <= 1'b0;
      half_q   <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        write_q  <= bus.req_write;
        half_q   <= bus.req_half;
        signed_q <= bus.req_signed;
        err_q    <= align_err || range_err;
        addr_q   <= addr_eff;
        wdata_q  <= bus.req_wdata;
        lo_q     <= '0;
        hi_q     <= '0;
      end
      if (state == LO && !write_q) lo_q <= bus.mem_rdata[15:0];
      if (state == HI && !write_q) hi_q <= bus.mem_rdata[15:0];
    end
  end

  // memory strobes decode from registered state only, so reset drops them at once
  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_w     = 1'b0;
    bus.mem_r     = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) state_nx = (align_err || range_err) ? RESP : LO;
      end
      LO: begin
        bus.mem_addr  = addr_q;
        bus.mem_wdata = {16'h0, wdata_q[15:0]};
        bus.mem_w     = write_q;
        bus.mem_r     = !write_q;
        state_nx      = half_q ? RESP : HI;
      end
      HI: begin
        bus.mem_addr  = addr_q + ADDR_W'(2);
        bus.mem_wdata = {16'h0, wdata_q[31:16]};
        bus.mem_w     = write_q;
        bus.mem_r     = !write_q;
        state_nx      = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        if (!err_q && !write_q)
          bus.rsp_rdata = half_q ? {{16{signed_q & lo_q[15]}}, lo_q} : {hi_q, lo_q};
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a byte-array memory reference
module tb_load_store_unit;
  localparam int ADDR_W    = 16;
  localparam int MEM_BYTES = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // device memory: 256 halves, indexed by byte address [8:1]
  logic [15:0] mem      [0:255];
  logic [15:0] init_val [0:255];
  logic        mem_init = 1'b1;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val[i];
    end else if (bus.mem_w) begin
      mem[bus.mem_addr[8:1]] <= bus.mem_wdata[15:0];
    end
  end
  assign bus.mem_rdata = bus.mem_r ? {16'h0, mem[bus.mem_addr[8:1]]} : 32'h0;

  // reference: flat little-endian byte array
  logic [7:0] ref_bytes [0:MEM_BYTES-1];

  typedef struct {
    bit          write;
    bit          half;
    int          addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          lat;
    int          nstrobe;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t model(bit w, bit h, bit s, int a, logic [31:0] wd);
    exp_t e;
    int   size;
    int   ea;
    bit   misal;
    size = h ? 2 : 4;
    ea   = a;
`ifdef LSU_ALIGN_CHECK_EN
    misal = (a % size) != 0;
`else
    misal = 1'b0;
    ea    = a - (a % size);
`endif
    e.write   = w;
    e.half    = h;
    e.addr    = ea;
    e.wdata   = wd;
    e.err     = misal || (ea + size > MEM_BYTES);
    e.lat     = e.err ? 1 : (h ? 2 : 3);
    e.nstrobe = e.err ? 0 : size / 2;
    e.rdata   = 32'h0;
    if (!e.err) begin
      if (w) begin
        for (int i = 0; i < size; i++) ref_bytes[ea + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) e.rdata[8*i +: 8] = ref_bytes[ea + i];
        if (h && s && e.rdata[15]) e.rdata[31:16] = 16'hFFFF;
      end
    end
    return e;
  endfunction

  // monitor
  int cyc      = 0;
  int acc_cyc  = 0;
  int strobe_k = 0;

  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] hw;
    cyc++;
    if (!rst) begin
      if (bus.req_valid && bus.req_ready) begin
        acc_cyc  = cyc;
        strobe_k = 0;
      end
      if (bus.mem_r || bus.mem_w) begin
        if (exp_q.size() == 0) begin
          chk("strobe_without_request", {30'h0, bus.mem_w, bus.mem_r}, 32'h0);
        end else begin
          e  = exp_q[0];
          hw = (strobe_k == 0) ? e.wdata[15:0] : e.wdata[31:16];
          chk("strobe_allowed", strobe_k < e.nstrobe, 1);
          chk("strobe_addr", {16'h0, bus.mem_addr}, e.addr + 2 * strobe_k);
          chk("strobe_kind", {30'h0, bus.mem_w, bus.mem_r}, {30'h0, e.write, !e.write});
          if (e.write) chk("strobe_wdata", bus.mem_wdata, {16'h0, hw});
          strobe_k++;
        end
      end
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_without_request", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
          chk("rsp_latency", cyc - acc_cyc, e.lat);
          chk("strobe_count", strobe_k, e.nstrobe);
        end
      end
    end
  end

  task automatic drive_inputs(bit v, bit w, bit h, bit s, int a, logic [31:0] wd);
    bus.req_valid  = v;
    bus.req_write  = w;
    bus.req_half   = h;
    bus.req_signed = s;
    bus.req_addr   = a[ADDR_W-1:0];
    bus.req_wdata  = wd;
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    ok = bus.req_ready;
    if (!ok) chk("ready_timeout", 32'h0, 32'h1);
  endtask

  task automatic do_req(bit w, bit h, bit s, int a, logic [31:0] wd);
    bit ok;
    @(posedge clk);
    #1;
    drive_inputs(1'b1, w, h, s, a, wd);
    wait_ready(ok);
    if (ok) exp_q.push_back(model(w, h, s, a, wd));
    @(posedge clk);
    #1;
    drive_inputs(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 65535), $urandom);
  endtask

  initial begin
    int          r;
    int          a;
    int          mism;
    int          n;
    bit          ok;
    logic [15:0] v;
    logic [7:0]  save2, save3;

    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      init_val[i]          = v;
      ref_bytes[2*i]       = v[7:0];
      ref_bytes[2*i + 1]   = v[15:8];
    end
    drive_inputs(1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    #3;
    chk("reset_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("reset_rsp", {30'h0, bus.rsp_valid, bus.rsp_err}, 32'h0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_mem_addr", {16'h0, bus.mem_addr}, 32'h0);
    chk("reset_mem_wdata", bus.mem_wdata, 32'h0);
    chk("reset_strobes", {30'h0, bus.mem_w, bus.mem_r}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    rst      = 1'b0;

    do_req(1, 0, 0, 16'h0010, 32'h12345678);
    do_req(0, 0, 0, 16'h0010, 32'h0);
    do_req(1, 1, 0, 16'h0020, 32'h00008001);
    do_req(0, 1, 1, 16'h0020, 32'h0);
    do_req(0, 1, 0, 16'h0020, 32'h0);
    do_req(0, 0, 0, 16'h01FE, 32'h0);
    do_req(0, 0, 0, 16'h0012, 32'h0);
    do_req(1, 1, 0, 16'h01FE, 32'h0000BEEF);
    do_req(0, 0, 0, 16'hFFFE, 32'h0);

    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = $urandom_range(0, MEM_BYTES - 1);
      else if (r == 8) a = $urandom_range(MEM_BYTES - 8, MEM_BYTES - 1);
      else             a = $urandom_range(0, 65535);
      do_req($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), a, $urandom);
    end

    // reset during the high half of a word store
    save2 = ref_bytes[16'h42];
    save3 = ref_bytes[16'h43];
    @(posedge clk);
    #1;
    drive_inputs(1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 32'hAABBCCDD);
    wait_ready(ok);
    if (ok) exp_q.push_back(model(1, 0, 0, 16'h0040, 32'hAABBCCDD));
    ref_bytes[16'h42] = save2;
    ref_bytes[16'h43] = save3;
    @(posedge clk);
    #1;
    drive_inputs(1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    @(posedge clk);
    #2;
    chk("hi_store_active", {bus.mem_addr, 15'h0, bus.mem_w}, {16'h0042, 15'h0, 1'b1});
    rst = 1'b1;
    #1;
    chk("abort_strobes", {30'h0, bus.mem_w, bus.mem_r}, 32'h0);
    chk("abort_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("abort_mem_addr", {16'h0, bus.mem_addr}, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      n += bus.rsp_valid;
    end
    chk("abort_no_rsp", n, 0);
    chk("abort_low_half", {16'h0, mem[16'h20]}, 32'h0000CCDD);
    chk("abort_high_half", {16'h0, mem[16'h21]}, {16'h0, save3, save2});

    do_req(0, 0, 0, 16'h0040, 32'h0);
    do_req(0, 1, 1, 16'h0040, 32'h0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", exp_q.size(), 0);

    mism = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== {ref_bytes[2*i + 1], ref_bytes[2*i]}) mism++;
    chk("memory_contents", mism, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
